data_memory_bytewise: RTL and testbench
=======================================

// Module: data_memory_bytewise
// PURPOSE
//  Parametrised successor of the single-word data memory: byte-addressed, byte/half/word access, sign/zero-extending loads.
//  Configurable read latency; post-reset init sweep; alignment/range faults.
//  Sits in the MEM stage; Ready stalls the pipeline during init.
// PARAMETERS
//  DATA_W   32   word width; must be 32 (byte lanes fixed at 4)
//  DEPTH    256  words of storage; power of two, >= 4
//  ADDR_W   32   byte-address width
//  RD_LAT   1    load latency in cycles, 1..3
// PORTS
//  Clk      in   1        clock, all state on rising edge
//  Rst_n    in   1        asynchronous active-low reset
//  Ready    out  1        1 = accepting requests; 0 during init sweep
//  MR       in   1        load request, sampled when Ready=1
//  MW       in   1        store request, sampled when Ready=1
//  Size     in   2        00 byte, 01 half, 10 word, 11 illegal
//  Unsgn    in   1        1 = zero-extend load, 0 = sign-extend
//  Addr     in   ADDR_W   byte address
//  WD       in   DATA_W   store data, right-justified (low bits used)
//  RD       out  DATA_W   extended load data, valid when RValid=1
//  RValid   out  1        one-cycle pulse, RD_LAT cycles after an accepted MR
//  Fault    out  1        one-cycle pulse, RD_LAT cycles after a faulting request
// BEHAVIOUR
//  - Reset (async, Rst_n=0): Ready=0, RD=0, RValid=0, Fault=0, in-flight loads discarded, FSM->INIT, sweep counter=0.
//  - FSM INIT: each cycle writes MEM[cnt]=cnt, cnt++; after MEM[DEPTH-1] written -> RUN (Ready=1 next cycle).
//    Init takes exactly DEPTH cycles after Rst_n rises. Reset mid-sweep restarts at 0.
//  - FSM RUN: Ready=1 forever; no other state. MR/MW ignored while Ready=0.
//  - Word index = Addr[log2(DEPTH)+1:2]; lane = Addr[1:0]. Little-endian byte lanes.
//  - Fault when request (MR|MW) and any of: Size=11; Size=01 & Addr[0]; Size=10 & Addr[1:0]!=0;
//    Addr >= DEPTH*4. Faulting request: no write, RValid=0, RD unchanged, Fault pulses at same latency a load would.
//  - Store: Size byte -> WD[7:0] to lane; half -> WD[15:0] to lanes {a+1,a}; word -> all. Other lanes untouched.
//    Write lands at end of accept cycle.
//  - Load: word read, lane(s) selected, extended per Unsgn to DATA_W; result on RD with RValid after RD_LAT cycles.
//    Fully pipelined: one accepted load per cycle, results in order.
//  - MR&MW same cycle, same word: load returns OLD contents (read-before-write), store still applied.
//  - Store at cycle N then load same word at N+1: load sees new data (no stale forwarding path needed since write precedes read).
//  - RD holds last valid load value between RValid pulses; cleared only by reset.
//  - No wrap-around of Addr: out-of-range is a fault, never aliased.
// STRUCTURE
//  - dmem_pkg: SZ_B/SZ_H/SZ_W/SZ_BAD size codes, FSM state encoding {ST_INIT, ST_RUN}, lane-mask function.
//  - Sub-module dmem_rd_pipe: RD_LAT-deep shift of {valid, fault, lane, size, unsgn, word}; performs extract/extend at output.
//  - Top: FSM + init counter, fault decode, byte-enable write into reg array MEM[0:DEPTH-1].
// TESTING
//  1 Reset, release: Ready=0 for exactly 256 cycles, then 1; word load Addr=0x40 -> RD=0x00000010, RValid after RD_LAT.
//  2 sw 0x80FF7F01 @0x100; lb @0x100 -> 0x00000001; lb @0x103 -> 0xFFFFFF80; lbu @0x103 -> 0x00000080;
//    lh @0x102 -> 0xFFFF80FF; lhu @0x102 -> 0x000080FF.
//  3 sb 0xAB @0x205 over word 0x81 -> word reads 0x0000AB81; sh 0x1234 @0x206 -> 0x1234AB81.
//  4 lw @0x102, lh @0x101, Size=11, lw @0x400 -> Fault pulse each, RValid=0; stores with same faults leave memory unchanged.
//  5 MR&MW word @0x10 with WD=0xDEADBEEF -> RD=0x00000004; next lw @0x10 -> 0xDEADBEEF.
//  6 RD_LAT=3, back-to-back 4 loads, Rst_n low mid-stream -> no RValid after reset; Ready low, sweep restarts, contents reinit.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
package dmem_pkg;

    // Access size codes as presented on the Size port
    typedef enum logic [1:0] {
        SzB   = 2'b00,
        SzH   = 2'b01,
        SzW   = 2'b10,
        SzBad = 2'b11
    } size_e;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    // One slot of the load-return pipeline; the extract/extend happens at its tail
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [1:0]  lane;
        size_e       size;
        logic        unsgn;
        logic [31:0] word;
    } rd_stage_t;

    // Byte-enable mask for an access of the given size starting at the given lane
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SzB:     mask = 4'b0001 << lane;
            SzH:     mask = lane[1] ? 4'b1100 : 4'b0011;
            SzW:     mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Load-return pipeline: RdLat-deep shift of load/fault tokens, with lane
// extraction and sign/zero extension at the output. RD holds the last load.
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned RdLat = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  rd_stage_t   stage_i,
    output logic [31:0] rd_o,
    output logic        rvalid_o,
    output logic        fault_o
);

    rd_stage_t   stage_q [RdLat];
    rd_stage_t   last;
    logic [31:0] shifted;
    logic [31:0] ext;
    logic [31:0] rd_hold_q;

    // Shift register; reset drops every in-flight token
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RdLat); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= stage_i;
            for (int i = 1; i < int'(RdLat); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Select the addressed lane(s) and extend to a full word
    always_comb begin
        last    = stage_q[RdLat-1];
        shifted = last.word >> {last.lane, 3'b000};
        ext     = last.word;
        case (last.size)
            SzB:     ext = last.unsgn ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SzH:     ext = last.unsgn ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = last.word;
        endcase
    end

    // Remember the most recent load result so RD is stable between pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_hold_q <= '0;
        end else if (last.valid) begin
            rd_hold_q <= ext;
        end
    end

    // Drive outputs from the pipeline tail
    always_comb begin
        rvalid_o = last.valid;
        fault_o  = last.fault;
        rd_o     = last.valid ? ext : rd_hold_q;
    end

endmodule

// File: rtl/data_memory_bytewise.sv
// Byte-addressed data memory for the MEM stage: byte/half/word access,
// sign/zero-extending loads, pipelined read latency, post-reset init sweep
// (MEM[i] = i) and alignment/range faults.
module data_memory_bytewise
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic              Ready,
    input  logic              MR,
    input  logic              MW,
    input  logic [1:0]        Size,
    input  logic              Unsgn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
    output logic              RValid,
    output logic              Fault
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] AddrLim = ADDR_W'(DEPTH * 4);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic              init_we;

    logic [DATA_W-1:0] mem_q [DEPTH];

    size_e             size;
    logic [IdxW-1:0]   word_idx;
    logic [1:0]        lane;
    logic              req;
    logic              misalign;
    logic              fault;
    logic              ld_ok;
    logic              st_ok;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    rd_stage_t         stage_in;

    // FSM and sweep-counter registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Init sweep writes one word per cycle, then RUN is permanent
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            StInit: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IdxW'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: state_d = StInit;
        endcase
    end

    // Request decode, fault detection and store lane steering
    always_comb begin
        Ready    = (state_q == StRun);
        size     = size_e'(Size);
        word_idx = Addr[IdxW+1:2];
        lane     = Addr[1:0];
        req      = Ready & (MR | MW);
        misalign = 1'b0;
        case (size)
            SzH:     misalign = Addr[0];
            SzW:     misalign = |Addr[1:0];
            SzBad:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
        // Out-of-range addresses fault rather than alias onto low words
        fault = req & (misalign | (Addr >= AddrLim));
        ld_ok = req & MR & ~fault;
        st_ok = req & MW & ~fault;
        be    = lane_mask(size, lane);
        case (size)
            SzB:     wdata = {4{WD[7:0]}};
            SzH:     wdata = {2{WD[15:0]}};
            default: wdata = WD;
        endcase
        // Read happens before this cycle's store lands, so MR&MW returns old data
        stage_in.valid = ld_ok;
        stage_in.fault = fault;
        stage_in.lane  = lane;
        stage_in.size  = size;
        stage_in.unsgn = Unsgn;
        stage_in.word  = mem_q[word_idx];
    end

    // Storage: sweep writes during init, byte-enabled stores afterwards
    always_ff @(posedge Clk) begin
        if (init_we) begin
            mem_q[cnt_q] <= DATA_W'(cnt_q);
        end else if (st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    dmem_rd_pipe #(
        .RdLat (RD_LAT)
    ) u_rd_pipe (
        .clk_i    (Clk),
        .rst_ni   (Rst_n),
        .stage_i  (stage_in),
        .rd_o     (RD),
        .rvalid_o (RValid),
        .fault_o  (Fault)
    );

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Scoreboard bench for data_memory_bytewise with a 3-cycle load latency.
module tb_data_memory_bytewise;

    localparam int RdLat = 3;
    localparam int Depth = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ready;
    logic        mr    = 1'b0;
    logic        mw    = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic        unsgn = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wd    = '0;
    logic [31:0] rd;
    logic        rvalid;
    logic        fault;

    always #5 clk = ~clk;

    data_memory_bytewise #(
        .DATA_W (32),
        .DEPTH  (Depth),
        .ADDR_W (32),
        .RD_LAT (RdLat)
    ) dut (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Ready  (ready),
        .MR     (mr),
        .MW     (mw),
        .Size   (size),
        .Unsgn  (unsgn),
        .Addr   (addr),
        .WD     (wd),
        .RD     (rd),
        .RValid (rvalid),
        .Fault  (fault)
    );

    typedef struct {
        logic        is_fault;
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count rising edges and compare every DUT output against the scoreboard head
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n && (rvalid || fault)) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious", {30'b0, rvalid, fault}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("kind", {30'b0, rvalid, fault}, mon_e.is_fault ? 32'd1 : 32'd2);
                check_eq("latency", 32'(cyc), 32'(mon_e.due));
                if (!mon_e.is_fault) check_eq("rd", rd, mon_e.rd);
            end
        end
    end

    task automatic issue(input logic m_r, input logic m_w, input logic [1:0] sz,
                         input logic un, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_f, input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        mr = m_r; mw = m_w; size = sz; unsgn = un; addr = a; wd = d;
        e.is_fault = exp_f;
        e.rd       = exp_rd;
        e.due      = cyc + RdLat;
        if ((m_r || m_w) && (exp_f || m_r)) sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        mr = 1'b0; mw = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("init_len", 32'(n), 32'(Depth));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got 0 expected finish");
        $fatal(1);
    end

    initial begin
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_ready", {31'b0, ready}, 32'd0);
        check_eq("rst_rd", rd, 32'd0);
        check_eq("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check_eq("rst_fault", {31'b0, fault}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready();

        // Init contents and basic word load
        issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h0000_0010);
        drain();

        // Word store then extending loads
        issue(0, 1, 2'b10, 0, 32'h100, 32'h80FF_7F01, 0, 32'h0);
        issue(1, 0, 2'b00, 0, 32'h100, 32'h0, 0, 32'h0000_0001);
        issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'hFFFF_FF80);
        issue(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h0000_0080);
        issue(1, 0, 2'b01, 0, 32'h102, 32'h0, 0, 32'hFFFF_80FF);
        issue(1, 0, 2'b01, 1, 32'h102, 32'h0, 0, 32'h0000_80FF);
        drain();

        // Partial stores leave other lanes untouched
        issue(0, 1, 2'b00, 0, 32'h205, 32'h5555_55AB, 0, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h204, 32'h0, 0, 32'h0000_AB81);
        issue(0, 1, 2'b01, 0, 32'h206, 32'hAAAA_1234, 0, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h204, 32'h0, 0, 32'h1234_AB81);
        drain();

        // Faulting loads and stores
        issue(1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h0);
        issue(1, 0, 2'b01, 0, 32'h101, 32'h0, 1, 32'h0);
        issue(1, 0, 2'b11, 0, 32'h100, 32'h0, 1, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h400, 32'h0, 1, 32'h0);
        issue(0, 1, 2'b10, 0, 32'h102, 32'h1111_1111, 1, 32'h0);
        issue(0, 1, 2'b01, 0, 32'h101, 32'h2222_2222, 1, 32'h0);
        issue(0, 1, 2'b11, 0, 32'h100, 32'h3333_3333, 1, 32'h0);
        issue(0, 1, 2'b10, 0, 32'h400, 32'h4444_4444, 1, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'h80FF_7F01);
        issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h0000_0000);
        issue(1, 0, 2'b10, 0, 32'h3FC, 32'h0, 0, 32'h0000_00FF);
        drain();

        // Read-before-write on simultaneous MR&MW, then new data next cycle
        issue(1, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0000_0004);
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);
        drain();
        repeat (2) @(negedge clk);
        check_eq("rd_hold", rd, 32'hDEAD_BEEF);

        // Reset in the middle of a back-to-back load stream
        issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h1);
        issue(1, 0, 2'b10, 0, 32'h8, 32'h0, 0, 32'h2);
        issue(1, 0, 2'b10, 0, 32'hC, 32'h0, 0, 32'h3);
        @(negedge clk);
        mr = 1'b0;
        rst_n = 1'b0;
        check_eq("flushed_cnt", 32'(sb_q.size()), 32'd2);
        sb_q.delete();
        #1;
        check_eq("mid_rst_rd", rd, 32'd0);
        check_eq("mid_rst_ready", {31'b0, ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_no_rvalid", {30'b0, rvalid, fault}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0000_0004);
        issue(1, 0, 2'b10, 0, 32'h204, 32'h0, 0, 32'h0000_0081);
        issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'h0000_0040);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
